dmem_bank_responder: RTL and testbench

- Responder side of the data-memory request interface. Consumes the en_b/rw/cs/addr request stream that the core's memory wrapper drives toward data RAM.
- Owns NBANK single-port synchronous RAM banks and performs writes.
- Returns read data through a 2-stage pipeline that freezes with t_cs.
- Runs a post-reset zero-initialisation sweep before accepting traffic.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_bank.sv | 32 +++
 rtl/dmem_bank_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_bank_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bank responder: default widths,
// FSM state encoding and request direction encoding.
package dmem_pkg;

    localparam int DMEM_DATA_W    = 32;
    localparam int DMEM_SUBADDR_W = 8;
    localparam int DMEM_CS_W      = 5;
    localparam int DMEM_NBANK     = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_e;

    // Request direction on ipt_wrp_to_dram_rw
    localparam logic DMEM_RD = 1'b1;
    localparam logic DMEM_WR = 1'b0;

    // Width of the internal bank-select index; never narrower than one bit
    function automatic int bank_sel_w(input int nbank);
        return (nbank > 1) ? $clog2(nbank) : 1;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM bank, read-first: a write cycle returns the
// word's previous contents on rdata. rdata holds while en is low.
module dmem_bank #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Registered read of the old word, optional write of the new one
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_bank_responder.sv
// Data-memory responder: decodes the wrapper's en_b/rw/cs/addr request
// stream onto NBANK RAM banks, zero-sweeps the banks after reset, and
// returns read data through a 2-stage pipeline that freezes with t_cs.
// Optional build macro: DMEM_PARITY_EN (per-word even parity, checked on read).
module dmem_bank_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W    = dmem_pkg::DMEM_DATA_W,
    parameter int SUBADDR_W = dmem_pkg::DMEM_SUBADDR_W,
    parameter int CS_W      = dmem_pkg::DMEM_CS_W,
    parameter int NBANK     = dmem_pkg::DMEM_NBANK
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 t_cs,
    input  logic                 ipt_wrp_to_dram_en_b,
    input  logic                 ipt_wrp_to_dram_rw,
    input  logic [CS_W-1:0]      ipt_wrp_to_dram_cs,
    input  logic [SUBADDR_W-1:0] ipt_wrp_to_dram_addr,
    input  logic [DATA_W-1:0]    ipt_wrp_to_dram_wdata,
    output logic [DATA_W-1:0]    opt_dram_rdata,
    output logic                 opt_dram_rvalid,
    output logic                 opt_dram_busy,
    output logic                 opt_dram_err
);

`ifdef DMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int BSEL_W = bank_sel_w(NBANK);
    localparam int NSLOT  = 1 << BSEL_W;
    localparam logic [CS_W:0] NBANK_L = (CS_W+1)'(NBANK);

    dmem_state_e           state_q, state_d;
    logic [SUBADDR_W-1:0]  cnt_q, cnt_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [BSEL_W-1:0]     s1_bank_q, s1_bank_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  cs_ok;
    logic                  acc_ok;
    logic                  acc_rd;
    logic                  drop;
    logic                  init_we;
    logic [BSEL_W-1:0]     req_sel;
    logic                  ram_we;
    logic [SUBADDR_W-1:0]  ram_addr;
    logic [WORD_W-1:0]     ram_wdata;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     s1_word;
    logic [WORD_W-1:0]     bank_rd [NSLOT];

`ifdef DMEM_PARITY_EN
    // Even parity: stored bit makes the XOR of the whole word zero
    assign wr_word = {^ipt_wrp_to_dram_wdata, ipt_wrp_to_dram_wdata};
`else
    assign wr_word = ipt_wrp_to_dram_wdata;
`endif

    assign req_sel = ipt_wrp_to_dram_cs[BSEL_W-1:0];
    assign s1_word = bank_rd[s1_bank_q];

    // Request decode and shared RAM port steering (sweep owns the port in INIT)
    always_comb begin
        accept    = t_cs && !ipt_wrp_to_dram_en_b;
        cs_ok     = {1'b0, ipt_wrp_to_dram_cs} < NBANK_L;
        acc_ok    = accept && (state_q == ST_RUN) && cs_ok;
        acc_rd    = acc_ok && (ipt_wrp_to_dram_rw == DMEM_RD);
        drop      = accept && !((state_q == ST_RUN) && cs_ok);
        init_we   = (state_q == ST_INIT) && reset_b;
        ram_we    = init_we || (acc_ok && (ipt_wrp_to_dram_rw == DMEM_WR));
        ram_addr  = init_we ? cnt_q : ipt_wrp_to_dram_addr;
        ram_wdata = init_we ? '0 : wr_word;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_bank
            if (gi < NBANK) begin : g_impl
                logic bank_en;
                assign bank_en = init_we || (acc_ok && (req_sel == BSEL_W'(gi)));
                dmem_bank #(
                    .WORD_W (WORD_W),
                    .ADDR_W (SUBADDR_W)
                ) u_bank (
                    .clk   (clk),
                    .en    (bank_en),
                    .we    (ram_we),
                    .addr  (ram_addr),
                    .wdata (ram_wdata),
                    .rdata (bank_rd[gi])
                );
            end else begin : g_pad
                assign bank_rd[gi] = '0;
            end
        end
    endgenerate

    // Next-state for the sweep FSM, read pipeline and error pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_valid_d = s1_valid_q;
        s1_bank_d  = s1_bank_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        err_d      = drop;

        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {SUBADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end
        end

        // Both stages advance only on enabled cycles
        if (t_cs) begin
            s1_valid_d = acc_rd;
            if (acc_rd) begin
                s1_bank_d = req_sel;
            end
            rvalid_d = s1_valid_q;
            if (s1_valid_q) begin
                rdata_d = s1_word[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
                if (^s1_word) begin
                    err_d = 1'b1;
                end
`endif
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_bank_q  <= s1_bank_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    assign opt_dram_rdata  = rdata_q;
    assign opt_dram_rvalid = rvalid_q;
    assign opt_dram_busy   = (state_q == ST_INIT);
    assign opt_dram_err    = err_q;

endmodule

// File: tb/tb_dmem_bank_responder.sv
// Self-checking bench for dmem_bank_responder: vector table, hand-written
// reset/sweep sequences and a randomized run against a queue-based model.
module tb_dmem_bank_responder;

    localparam int DATA_W    = 32;
    localparam int SUBADDR_W = 8;
    localparam int CS_W      = 5;
    localparam int NBANK     = 4;
    localparam int DEPTH     = 256;
    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    logic                 clk = 1'b0;
    logic                 reset_b;
    logic                 t_cs;
    logic                 en_b;
    logic                 rw;
    logic [CS_W-1:0]      cs;
    logic [SUBADDR_W-1:0] addr;
    logic [DATA_W-1:0]    wdata;
    logic [DATA_W-1:0]    rdata;
    logic                 rvalid;
    logic                 busy;
    logic                 err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_bank_responder #(
        .DATA_W    (DATA_W),
        .SUBADDR_W (SUBADDR_W),
        .CS_W      (CS_W),
        .NBANK     (NBANK)
    ) u_dut (
        .clk                   (clk),
        .reset_b               (reset_b),
        .t_cs                  (t_cs),
        .ipt_wrp_to_dram_en_b  (en_b),
        .ipt_wrp_to_dram_rw    (rw),
        .ipt_wrp_to_dram_cs    (cs),
        .ipt_wrp_to_dram_addr  (addr),
        .ipt_wrp_to_dram_wdata (wdata),
        .opt_dram_rdata        (rdata),
        .opt_dram_rvalid       (rvalid),
        .opt_dram_busy         (busy),
        .opt_dram_err          (err)
    );

    typedef struct {
        logic                 t_cs;
        logic                 en_b;
        logic                 rw;
        logic [CS_W-1:0]      cs;
        logic [SUBADDR_W-1:0] addr;
        logic [DATA_W-1:0]    wdata;
        logic                 exp_rvalid;
        logic                 exp_err;
        logic [DATA_W-1:0]    exp_rdata;
    } vec_t;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } pend_t;

    vec_t              vecs [21];
    logic [DATA_W-1:0] mdl_mem [NBANK][DEPTH];
    pend_t             pend [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic eb, input logic r,
                         input logic [CS_W-1:0] c, input logic [SUBADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        t_cs  = t;
        en_b  = eb;
        rw    = r;
        cs    = c;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, RD, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic t, input logic eb, input logic r,
                                input logic [CS_W-1:0] c, input logic [SUBADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic erv,
                                input logic eerr, input logic [DATA_W-1:0] erd);
        vec_t v;
        v.t_cs = t; v.en_b = eb; v.rw = r; v.cs = c; v.addr = a; v.wdata = d;
        v.exp_rvalid = erv; v.exp_err = eerr; v.exp_rdata = erd;
        return v;
    endfunction

    initial begin
        int n;
        int rv_seen;
        int en_idx;
        logic e_rv;
        logic e_err;
        logic [DATA_W-1:0] e_rd;

        // Expected outputs are those sampled just after each row's clock edge
        vecs[0]  = mk(1, 0, WR, 1, 8'h05, 32'hDEADBEEF, 0, 0, 32'h0);
        vecs[1]  = mk(1, 0, RD, 1, 8'h05, 32'h0,        0, 0, 32'h0);
        vecs[2]  = mk(1, 0, RD, 0, 8'h05, 32'h0,        1, 0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 0, RD, 1, 8'h05, 32'h0,        1, 0, 32'h0);
        vecs[4]  = mk(1, 0, WR, 1, 8'h05, 32'h12345678, 1, 0, 32'hDEADBEEF);
        vecs[5]  = mk(1, 0, RD, 1, 8'h05, 32'h0,        0, 0, 32'hDEADBEEF);
        vecs[6]  = mk(1, 1, RD, 0, 8'h00, 32'h0,        1, 0, 32'h12345678);
        vecs[7]  = mk(1, 0, RD, 2, 8'h10, 32'h0,        0, 0, 32'h12345678);
        vecs[8]  = mk(1, 0, WR, 4, 8'h05, 32'hFFFFFFFF, 1, 1, 32'h0);
        vecs[9]  = mk(1, 0, RD, 4, 8'h05, 32'h0,        0, 1, 32'h0);
        vecs[10] = mk(1, 0, RD, 31, 8'h05, 32'h0,       0, 1, 32'h0);
        vecs[11] = mk(1, 1, RD, 0, 8'h00, 32'h0,        0, 0, 32'h0);
        vecs[12] = mk(1, 0, RD, 1, 8'h05, 32'h0,        0, 0, 32'h0);
        vecs[13] = mk(0, 1, RD, 0, 8'h00, 32'h0,        0, 0, 32'h0);
        vecs[14] = mk(0, 0, RD, 7, 8'h00, 32'h0,        0, 0, 32'h0);
        vecs[15] = mk(0, 1, RD, 0, 8'h00, 32'h0,        0, 0, 32'h0);
        vecs[16] = mk(1, 1, RD, 0, 8'h00, 32'h0,        1, 0, 32'h12345678);
        vecs[17] = mk(0, 1, RD, 0, 8'h00, 32'h0,        1, 0, 32'h12345678);
        vecs[18] = mk(1, 1, RD, 0, 8'h00, 32'h0,        0, 0, 32'h12345678);
        vecs[19] = mk(1, 0, RD, 0, 8'h05, 32'h0,        0, 0, 32'h12345678);
        vecs[20] = mk(1, 1, RD, 0, 8'h00, 32'h0,        1, 0, 32'h0);

        // Reset and reset-state outputs
        reset_b = 1'b0;
        idle();
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'h1);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        $display("TXN reset: busy=%0b rvalid=%0b rdata=0x%08h err=%0b", busy, rvalid, rdata, err);

        // Sweep length after reset release
        reset_b = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("init_len", 32'(n), 32'd256);
        $display("TXN init sweep: busy cycles=%0d", n);

        // Vector table
        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].t_cs, vecs[i].en_b, vecs[i].rw, vecs[i].cs, vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            $display("TXN vec%0d: t_cs=%0b en_b=%0b rw=%0b cs=%0d addr=0x%02h wdata=0x%08h -> rvalid=%0b err=%0b rdata=0x%08h",
                     i, vecs[i].t_cs, vecs[i].en_b, vecs[i].rw, vecs[i].cs, vecs[i].addr,
                     vecs[i].wdata, rvalid, err, rdata);
        end

        // Reset one cycle after a read is accepted: read is discarded
        drive(1, 0, RD, 1, 8'h05, 32'h0);
        tick();
        reset_b = 1'b0;
        idle();
        tick();
        chk("rst_mid_rvalid", 32'(rvalid), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h1);
        chk("rst_mid_rdata", rdata, 32'h0);
        $display("TXN reset mid-read: rvalid=%0b busy=%0b", rvalid, busy);

        // Request during the sweep is dropped with a one-cycle err pulse
        reset_b = 1'b1;
        drive(1, 0, RD, 0, 8'h00, 32'h0);
        tick();
        chk("init_req_err", 32'(err), 32'h1);
        chk("init_req_rvalid", 32'(rvalid), 32'h0);
        idle();
        tick();
        chk("init_req_err_len", 32'(err), 32'h0);
        $display("TXN request in INIT: err pulse observed, rvalid=%0b", rvalid);
        n = 2;
        rv_seen = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
            if (rvalid === 1'b1) rv_seen++;
        end
        chk("reinit_len", 32'(n), 32'd256);
        chk("reinit_no_rvalid", 32'(rv_seen), 32'h0);
        $display("TXN re-sweep: busy cycles=%0d stray rvalids=%0d", n, rv_seen);

        // Sweep cleared previously written word
        drive(1, 0, RD, 1, 8'h05, 32'h0);
        tick();
        idle();
        tick();
        chk("swept_rvalid", 32'(rvalid), 32'h1);
        chk("swept_rdata", rdata, 32'h0);
        $display("TXN read after sweep: rvalid=%0b rdata=0x%08h", rvalid, rdata);

        // Randomized traffic against a timestamp-queue model
        for (int b = 0; b < NBANK; b++)
            for (int w = 0; w < DEPTH; w++)
                mdl_mem[b][w] = '0;
        en_idx = 0;
        e_rv   = 1'b0;
        e_err  = 1'b0;
        e_rd   = 32'h0;
        for (int i = 0; i < 400; i++) begin
            logic tr, eb, r, acc;
            logic [CS_W-1:0] c;
            logic [SUBADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            tr = ($urandom_range(0, 9) < 8);
            eb = ($urandom_range(0, 9) < 3);
            r  = 1'($urandom_range(0, 1));
            c  = CS_W'($urandom_range(0, 5));
            a  = SUBADDR_W'($urandom_range(0, 7));
            d  = $urandom;
            drive(tr, eb, r, c, a, d);

            // Read data emerges on the enabled edge after the accepting one
            acc   = tr && !eb;
            e_err = acc && (int'(c) >= NBANK);
            if (tr) begin
                en_idx++;
                e_rv = 1'b0;
                if (pend.size() > 0 && pend[0].idx == en_idx - 1) begin
                    e_rv = 1'b1;
                    e_rd = pend[0].data;
                    void'(pend.pop_front());
                end
            end
            if (acc && int'(c) < NBANK) begin
                if (r == RD) pend.push_back('{en_idx, mdl_mem[c[1:0]][a]});
                else         mdl_mem[c[1:0]][a] = d;
            end

            tick();
            chk("rand_rvalid", 32'(rvalid), 32'(e_rv));
            chk("rand_err", 32'(err), 32'(e_err));
            chk("rand_rdata", rdata, e_rd);
            chk("rand_busy", 32'(busy), 32'h0);
            $display("TXN rand%0d: t_cs=%0b en_b=%0b rw=%0b cs=%0d addr=%0d -> rvalid=%0b err=%0b rdata=0x%08h",
                     i, tr, eb, r, c, a, rvalid, err, rdata);
        end

`ifdef DMEM_PARITY_EN
        // Parity: clean read, then a read of a word with a corrupted stored bit
        idle();
        tick();
        tick();
        drive(1, 0, WR, 1, 8'h20, 32'hA5A5A5A5);
        tick();
        drive(1, 0, RD, 1, 8'h20, 32'h0);
        tick();
        idle();
        tick();
        chk("par_clean_rvalid", 32'(rvalid), 32'h1);
        chk("par_clean_err", 32'(err), 32'h0);
        chk("par_clean_rdata", rdata, 32'hA5A5A5A5);
        u_dut.g_bank[1].g_impl.u_bank.mem_q[8'h20][3] = ~u_dut.g_bank[1].g_impl.u_bank.mem_q[8'h20][3];
        drive(1, 0, RD, 1, 8'h20, 32'h0);
        tick();
        idle();
        tick();
        chk("par_bad_rvalid", 32'(rvalid), 32'h1);
        chk("par_bad_err", 32'(err), 32'h1);
        chk("par_bad_rdata", rdata, 32'hA5A5A5AD);
        $display("TXN parity flip: rvalid=%0b err=%0b rdata=0x%08h", rvalid, err, rdata);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
